// File: rtl/btn_dir_arbiter.sv
// btn_dir_arbiter: four async direction buttons -> debounced presses -> round-robin pick -> 2-entry heading queue
//   clk, rst (async, active-high)
//   btn_up/btn_right/btn_down/btn_left : async buttons, 1 = pressed
//   tick       : game-step pulse, pops one queued direction into dir
//   clr        : sync restart, empties queue and sets dir to RIGHT
//   dir        : heading 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT
//   dir_chg    : pulse alongside a dir load from the queue
//   q_level    : queued entries 0..2
//   press_drop : pulse one cycle after a press lost to arbitration, reversal or full queue
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    m <= d;
    q <= m;
  end
endmodule

module btn_dir_arbiter #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       tick,
  input  logic       clr,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic [1:0] q_level,
  output logic       press_drop
);
  logic [3:0] btn, s, db_state, db_prev, press;
  logic [1:0] rr_ptr, win, idx, ref_dir, q0, q1, q0_p, q0_n, q1_n, lvl_p, lvl_n;
  logic       found, lose, same, rev, push, pop, drop_n;
  assign btn = {btn_left, btn_down, btn_right, btn_up};
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_btn
      logic [DB_W-1:0] cnt;
      logic            db;
      sync_2ff u_sync (.clk(clk), .d(btn[i]), .q(s[i]));
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          cnt <= '0;
          db  <= 1'b0;
        end else if (s[i] == db) cnt <= '0;
        else if (cnt == DB_W'(DB_CYCLES - 1)) begin
          db  <= s[i];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      assign db_state[i] = db;
    end
  endgenerate
  assign press = db_state & ~db_prev;
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (press[idx] && !found) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  // Compare against the newest queued heading so back-to-back presses are checked against each other
  assign ref_dir = q_level == 2'd2 ? q1 : (q_level != 2'd0 ? q0 : dir);
  assign lose    = found && (press != (4'b0001 << win));
  assign same    = win == ref_dir;
  assign rev     = win == (ref_dir ^ 2'b10);
  assign pop     = tick && q_level != 2'd0;
  // A full queue still accepts when the same cycle pops
  assign push    = !clr && found && !same && !rev && (q_level != 2'd2 || tick);
  assign drop_n  = !clr && found && (lose || rev || (!same && q_level == 2'd2 && !tick));
  assign lvl_p   = q_level - {1'b0, pop};
  assign q0_p    = pop ? q1 : q0;
  assign q0_n    = push && lvl_p == 2'd0 ? win : q0_p;
  assign q1_n    = push && lvl_p != 2'd0 ? win : q1;
  assign lvl_n   = lvl_p + {1'b0, push};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir        <= 2'b01;
      dir_chg    <= 1'b0;
      q_level    <= '0;
      press_drop <= 1'b0;
      rr_ptr     <= '0;
      q0         <= '0;
      q1         <= '0;
      db_prev    <= '0;
    end else begin
      press_drop <= drop_n;
      rr_ptr     <= found ? win + 2'd1 : rr_ptr;
      db_prev    <= db_state;
      dir_chg    <= pop && !clr;
      dir        <= clr ? 2'b01 : (pop ? q0 : dir);
      q_level    <= clr ? 2'd0 : lvl_n;
      q0         <= q0_n;
      q1         <= q1_n;
    end
endmodule

// File: tb/tb_btn_dir_arbiter.sv
// tb_btn_dir_arbiter: directed vectors with a scoreboard for dir_chg/press_drop events
module tb_btn_dir_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       tick = 1'b0, clr = 1'b0;
  logic [1:0] dir, q_level;
  logic       dir_chg, press_drop;
  int         vectors = 0, miscompares = 0;
  logic [1:0] exp_dir[$];
  bit         exp_drop[$];

  btn_dir_arbiter #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .btn_left(btn_left), .tick(tick), .clr(clr), .dir(dir), .dir_chg(dir_chg),
    .q_level(q_level), .press_drop(press_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial forever begin
    logic [1:0] e;
    @(negedge clk);
    if (!rst && dir_chg) begin
      vectors++;
      if (exp_dir.size() == 0) begin
        miscompares++;
        $display("FAIL dir_chg: unexpected pulse with dir=%0d, none required", dir);
      end else begin
        e = exp_dir.pop_front();
        if (dir !== e) begin
          miscompares++;
          $display("FAIL dir_load: got %0d required %0d", dir, e);
        end
      end
    end
    if (!rst && press_drop) begin
      vectors++;
      if (exp_drop.size() == 0) begin
        miscompares++;
        $display("FAIL press_drop: unexpected pulse, none required");
      end else void'(exp_drop.pop_front());
    end
  end

  task automatic check(string name, logic [1:0] got, logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(logic [3:0] m);
    {btn_left, btn_down, btn_right, btn_up} = m;
  endtask

  task automatic press_btns(logic [3:0] m);
    set_btns(m);
    cyc(9);
    set_btns(4'b0000);
    cyc(9);
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    check("rst_dir", dir, 2'b01);
    check("rst_qlevel", q_level, 2'd0);
    check("rst_dir_chg", {1'b0, dir_chg}, 2'd0);
    check("rst_press_drop", {1'b0, press_drop}, 2'd0);
    rst = 1'b0;
    cyc(2);
    // 1: short pulse rejected, long hold accepted
    set_btns(4'b0001);
    cyc(3);
    set_btns(4'b0000);
    cyc(10);
    check("short_pulse_qlevel", q_level, 2'd0);
    press_btns(4'b0001);
    check("up_held_qlevel", q_level, 2'd1);
    exp_dir.push_back(2'b00);
    pulse_tick();
    pulse_clr();
    check("clr_dir", dir, 2'b01);
    check("clr_qlevel", q_level, 2'd0);
    // 2: reversal dropped, same heading ignored
    exp_drop.push_back(1'b1);
    press_btns(4'b1000);
    check("reversal_qlevel", q_level, 2'd0);
    press_btns(4'b0010);
    check("same_dir_qlevel", q_level, 2'd0);
    // 3: two presses between ticks both take effect
    press_btns(4'b0001);
    press_btns(4'b1000);
    check("two_queued_qlevel", q_level, 2'd2);
    exp_dir.push_back(2'b00);
    pulse_tick();
    exp_dir.push_back(2'b11);
    pulse_tick();
    pulse_tick();
    check("drained_dir", dir, 2'b11);
    check("drained_qlevel", q_level, 2'd0);
    // 4: simultaneous UP+DOWN, round-robin alternates winner
    pulse_clr();
    exp_drop.push_back(1'b1);
    press_btns(4'b0101);
    check("rr_first_qlevel", q_level, 2'd1);
    exp_dir.push_back(2'b00);
    pulse_tick();
    pulse_clr();
    exp_drop.push_back(1'b1);
    press_btns(4'b0101);
    check("rr_second_qlevel", q_level, 2'd1);
    exp_dir.push_back(2'b10);
    pulse_tick();
    // 5: full queue drops, full queue plus tick accepts
    pulse_clr();
    press_btns(4'b0001);
    press_btns(4'b1000);
    check("full_qlevel", q_level, 2'd2);
    exp_drop.push_back(1'b1);
    press_btns(4'b0100);
    check("full_drop_qlevel", q_level, 2'd2);
    exp_dir.push_back(2'b00);
    set_btns(4'b0100);
    cyc(6);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    set_btns(4'b0000);
    cyc(9);
    check("push_pop_qlevel", q_level, 2'd2);
    exp_dir.push_back(2'b11);
    pulse_tick();
    exp_dir.push_back(2'b10);
    pulse_tick();
    check("order_dir", dir, 2'b10);
    check("order_qlevel", q_level, 2'd0);
    // 6: reset mid-debounce with a full queue
    pulse_clr();
    press_btns(4'b0001);
    press_btns(4'b1000);
    check("pre_rst_qlevel", q_level, 2'd2);
    set_btns(4'b0001);
    cyc(4);
    rst = 1'b1;
    #1;
    check("async_rst_dir", dir, 2'b01);
    check("async_rst_qlevel", q_level, 2'd0);
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check("post_rst_early_qlevel", q_level, 2'd0);
    cyc(4);
    check("post_rst_press_qlevel", q_level, 2'd1);
    set_btns(4'b0000);
    cyc(3);
    check("dir_events_left", 2'(exp_dir.size()), 2'd0);
    check("drop_events_left", 2'(exp_drop.size()), 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
